alu64bit_issue_seq: RTL and testbench

Issue/capture sequencer around the combinational ripple-carry alu64bit. It accepts operation requests on a valid/ready interface and registers the operands onto the ALU inputs. It then waits a fixed number of settle cycles for the ripple chain to resolve and captures s/cout into a result register. The result is presented on a valid/ready response interface. A carry flag enables multi-word chained arithmetic (cin taken from the previous cout).

---
 rtl/alu_seq_pkg.sv | 13 +
 rtl/alu64bit_issue_seq.sv | 126 ++++++++++++
 tb/tb_alu64bit_issue_seq.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu64bit issue/capture sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam int unsigned OP_W      = 2;
  localparam int unsigned DEF_WIDTH = 64;

endpackage

// File: rtl/alu64bit_issue_seq.sv
// Registers a request onto the ALU inputs, holds them for SETTLE_CYCLES while the
// ripple chain resolves, then captures s/cout behind a valid/ready response port.
module alu64bit_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic             req_cin,
  input  logic             req_chain,
  input  logic             flag_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic             busy
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu64bit_issue_seq: SETTLE_CYCLES must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry_flag;
  logic             accept;
  logic             capture;

  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign capture = (state == SETTLE) && (cnt == '0);
  assign busy    = (state != IDLE);

  // Operand registers feed the ALU directly; they move only on an accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_cin <= 1'b0;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_op  <= req_op;
      alu_cin <= req_chain ? carry_flag : req_cin;
    end
  end

  // Capture takes priority over a coincident clear; a chained accept on the
  // same edge has already sampled the pre-clear value above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (capture) begin
      carry_flag <= alu_cout;
    end else if (flag_clr) begin
      carry_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_s     <= alu_s;
            rsp_cout  <= alu_cout;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (req_valid) begin
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu64bit_issue_seq.sv
// Bench for alu64bit_issue_seq with delayed adder stubs standing in for the ripple ALU.
module tb_alu64bit_issue_seq;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         cin, chain, flag_clr, rsp_ready;
  logic         m_req_valid, s1_req_valid, s7_req_valid;

  logic         m_req_ready, m_rsp_valid, m_rsp_cout, m_alu_cin, m_alu_cout, m_busy;
  logic [W-1:0] m_rsp_s, m_alu_a, m_alu_b, m_alu_s;
  logic [1:0]   m_alu_op;
  logic         s1_req_ready, s1_rsp_valid, s1_rsp_cout, s1_alu_cin, s1_alu_cout, s1_busy;
  logic [W-1:0] s1_rsp_s, s1_alu_a, s1_alu_b, s1_alu_s;
  logic [1:0]   s1_alu_op;
  logic         s7_req_ready, s7_rsp_valid, s7_rsp_cout, s7_alu_cin, s7_alu_cout, s7_busy;
  logic [W-1:0] s7_rsp_s, s7_alu_a, s7_alu_b, s7_alu_s;
  logic [1:0]   s7_alu_op;

  int   total = 0;
  int   bad = 0;
  logic model_flag = 1'b0;

  alu64bit_issue_seq #(.WIDTH(W), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_a(a), .req_b(b), .req_op(op), .req_cin(cin), .req_chain(chain), .flag_clr(flag_clr),
    .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_s(m_rsp_s), .rsp_cout(m_rsp_cout),
    .alu_a(m_alu_a), .alu_b(m_alu_b), .alu_op(m_alu_op), .alu_cin(m_alu_cin),
    .alu_s(m_alu_s), .alu_cout(m_alu_cout), .busy(m_busy));

  alu64bit_issue_seq #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(s1_req_valid), .req_ready(s1_req_ready),
    .req_a(a), .req_b(b), .req_op(op), .req_cin(cin), .req_chain(chain), .flag_clr(flag_clr),
    .rsp_valid(s1_rsp_valid), .rsp_ready(rsp_ready), .rsp_s(s1_rsp_s), .rsp_cout(s1_rsp_cout),
    .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_op(s1_alu_op), .alu_cin(s1_alu_cin),
    .alu_s(s1_alu_s), .alu_cout(s1_alu_cout), .busy(s1_busy));

  alu64bit_issue_seq #(.WIDTH(W), .SETTLE_CYCLES(7)) dut_s7 (
    .clk(clk), .rst_n(rst_n), .req_valid(s7_req_valid), .req_ready(s7_req_ready),
    .req_a(a), .req_b(b), .req_op(op), .req_cin(cin), .req_chain(chain), .flag_clr(flag_clr),
    .rsp_valid(s7_rsp_valid), .rsp_ready(rsp_ready), .rsp_s(s7_rsp_s), .rsp_cout(s7_rsp_cout),
    .alu_a(s7_alu_a), .alu_b(s7_alu_b), .alu_op(s7_alu_op), .alu_cin(s7_alu_cin),
    .alu_s(s7_alu_s), .alu_cout(s7_alu_cout), .busy(s7_busy));

  // ALU stubs: 3-cycle delay for the main instance, 0 and 5 cycles for the sweep.
  logic [W:0] m_pipe [3];
  logic [W:0] s7_pipe [5];
  always_ff @(posedge clk) begin
    m_pipe[0] <= {1'b0, m_alu_a} + {1'b0, m_alu_b} + (W+1)'(m_alu_cin);
    m_pipe[1] <= m_pipe[0];
    m_pipe[2] <= m_pipe[1];
    s7_pipe[0] <= {1'b0, s7_alu_a} + {1'b0, s7_alu_b} + (W+1)'(s7_alu_cin);
    for (int i = 1; i < 5; i++) s7_pipe[i] <= s7_pipe[i-1];
  end
  assign {m_alu_cout, m_alu_s}   = m_pipe[2];
  assign {s7_alu_cout, s7_alu_s} = s7_pipe[4];
  assign {s1_alu_cout, s1_alu_s} = {1'b0, s1_alu_a} + {1'b0, s1_alu_b} + (W+1)'(s1_alu_cin);

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y};
    if (c) r = r + 1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_main(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [1:0] iop, input logic icin, input logic ichain);
    a = ia; b = ib; op = iop; cin = icin; chain = ichain; m_req_valid = 1'b1;
    #1;
    total++;
    if (m_req_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", m_req_ready); end
    step();
    m_req_valid = 1'b0;
  endtask

  task automatic wait_main(input int want_lat);
    int lat;
    lat = 0;
    while (m_rsp_valid !== 1'b1 && lat < 40) begin step(); lat++; end
    total++;
    if (lat != want_lat) begin bad++; $display("FAIL latency got=%0d want=%0d", lat, want_lat); end
  endtask

  task automatic retire_main();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({m_rsp_valid, m_busy, m_alu_cin, m_alu_op, m_rsp_cout} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {m_rsp_valid, m_busy, m_alu_cin, m_alu_op, m_rsp_cout});
    end
    total++;
    if ({m_alu_a, m_alu_b, m_rsp_s} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", m_alu_a, m_alu_b, m_rsp_s);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (m_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", m_req_ready); end
    model_flag = 1'b0;
  endtask

  task automatic test_basic();
    issue_main('1, 64'd1, 2'b11, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) step();
      else step();
      total++;
      if (m_rsp_valid !== (k == 4)) begin
        bad++; $display("FAIL basic_valid_e%0d got=%b want=%b", k, m_rsp_valid, (k == 4));
      end
      total++;
      if (m_alu_op !== 2'b11) begin bad++; $display("FAIL basic_op got=%b want=11", m_alu_op); end
    end
    total++;
    if ({m_rsp_cout, m_rsp_s} !== {1'b1, 64'd0}) begin
      bad++; $display("FAIL basic_result got=%b/%h want=1/0", m_rsp_cout, m_rsp_s);
    end
    model_flag = 1'b1;
  endtask

  task automatic test_backpressure();
    a = 64'h1234; b = 64'h5678; cin = 1'b1; chain = 1'b0; op = 2'b01;
    m_req_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({m_rsp_valid, m_req_ready, m_rsp_cout, m_rsp_s} !== {1'b1, 1'b0, 1'b1, 64'd0}) begin
        bad++; $display("FAIL bp_hold got=%b%b%b/%h want=101/0", m_rsp_valid, m_req_ready,
                        m_rsp_cout, m_rsp_s);
      end
      total++;
      if ({m_alu_a, m_alu_b, m_alu_op, m_alu_cin} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b11, 1'b0}) begin
        bad++; $display("FAIL bp_alu got=%h/%h/%b/%b", m_alu_a, m_alu_b, m_alu_op, m_alu_cin);
      end
    end
    m_req_valid = 1'b0;
    retire_main();
    total++;
    if ({m_rsp_valid, m_busy} !== 2'b00) begin
      bad++; $display("FAIL bp_retire got=%b%b want=00", m_rsp_valid, m_busy);
    end
  endtask

  task automatic test_back_to_back();
    issue_main('1, 64'd1, 2'b00, 1'b0, 1'b0);
    wait_main(4);
    total++;
    if (m_rsp_cout !== 1'b1) begin bad++; $display("FAIL b2b_first_cout got=%b want=1", m_rsp_cout); end
    a = '0; b = '0; chain = 1'b1; cin = 1'b0; m_req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    total++;
    if (m_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", m_req_ready); end
    step();
    m_req_valid = 1'b0; rsp_ready = 1'b0;
    total++;
    if ({m_rsp_valid, m_busy, m_alu_cin} !== 3'b011) begin
      bad++; $display("FAIL b2b_accept got=%b%b%b want=011", m_rsp_valid, m_busy, m_alu_cin);
    end
    wait_main(4);
    total++;
    if ({m_rsp_cout, m_rsp_s} !== {1'b0, 64'd1}) begin
      bad++; $display("FAIL b2b_result got=%b/%h want=0/1", m_rsp_cout, m_rsp_s);
    end
    model_flag = 1'b0;
    retire_main();
  endtask

  task automatic test_flag_clr();
    issue_main('1, 64'd1, 2'b10, 1'b0, 1'b0);
    wait_main(4);
    retire_main();
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    issue_main(64'd5, 64'd0, 2'b10, 1'b0, 1'b1);
    wait_main(4);
    total++;
    if ({m_rsp_cout, m_rsp_s} !== {1'b0, 64'd5}) begin
      bad++; $display("FAIL clr_result got=%b/%h want=0/5", m_rsp_cout, m_rsp_s);
    end
    retire_main();
    // clear held across the capture edge and the chained accept that follows
    flag_clr = 1'b1;
    issue_main('1, 64'd1, 2'b10, 1'b0, 1'b0);
    wait_main(4);
    a = '0; b = '0; chain = 1'b1; m_req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    m_req_valid = 1'b0; rsp_ready = 1'b0; flag_clr = 1'b0;
    total++;
    if (m_alu_cin !== 1'b1) begin bad++; $display("FAIL clr_capture_wins got=%b want=1", m_alu_cin); end
    wait_main(4);
    total++;
    if ({m_rsp_cout, m_rsp_s} !== {1'b0, 64'd1}) begin
      bad++; $display("FAIL clr_chain_result got=%b/%h want=0/1", m_rsp_cout, m_rsp_s);
    end
    model_flag = 1'b0;
    retire_main();
  endtask

  task automatic test_reset_mid_settle();
    issue_main('1, 64'd1, 2'b01, 1'b0, 1'b0);
    wait_main(4);
    retire_main();
    issue_main(64'd3, 64'd4, 2'b01, 1'b1, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_rsp_valid, m_busy, m_alu_cin, m_alu_op} !== 5'b0 || {m_alu_a, m_alu_b} !== '0) begin
      bad++; $display("FAIL mid_reset got=%b%b%b%b/%h/%h want=0", m_rsp_valid, m_busy,
                      m_alu_cin, m_alu_op, m_alu_a, m_alu_b);
    end
    step();
    rst_n = 1'b1;
    model_flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({m_rsp_valid, m_busy} !== 2'b00) begin
        bad++; $display("FAIL mid_reset_quiet got=%b%b want=00", m_rsp_valid, m_busy);
      end
    end
    issue_main('0, '0, 2'b00, 1'b1, 1'b1);
    total++;
    if (m_alu_cin !== 1'b0) begin bad++; $display("FAIL mid_reset_flag got=%b want=0", m_alu_cin); end
    wait_main(4);
    total++;
    if ({m_rsp_cout, m_rsp_s} !== {1'b0, 64'd0}) begin
      bad++; $display("FAIL mid_reset_result got=%b/%h want=0/0", m_rsp_cout, m_rsp_s);
    end
    retire_main();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rc, rch, eff;
    logic [W:0]   exp;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        flag_clr = 1'b1; step(); flag_clr = 1'b0; model_flag = 1'b0;
      end
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      rc  = 1'($urandom_range(0, 1));
      rch = 1'($urandom_range(0, 1));
      eff = rch ? model_flag : rc;
      exp = ref_add(ra, rb, eff);
      issue_main(ra, rb, rop, rc, rch);
      total++;
      if ({m_alu_op, m_alu_cin} !== {rop, eff}) begin
        bad++; $display("FAIL rand_alu_in[%0d] got=%b/%b want=%b/%b", i, m_alu_op, m_alu_cin, rop, eff);
      end
      wait_main(4);
      repeat ($urandom_range(0, 3)) step();
      total++;
      if ({m_rsp_cout, m_rsp_s} !== exp) begin
        bad++; $display("FAIL rand_result[%0d] got=%b/%h want=%b/%h", i, m_rsp_cout, m_rsp_s,
                        exp[W], exp[W-1:0]);
      end
      model_flag = exp[W];
      retire_main();
    end
  endtask

  task automatic test_settle_sweep(input int settle);
    logic [W-1:0] ra, rb;
    logic         rc, vld;
    logic [W:0]   exp, got;
    logic [1:0]   gop;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc; chain = 1'b0; op = 2'(i);
      exp = ref_add(ra, rb, rc);
      if (settle == 1) s1_req_valid = 1'b1; else s7_req_valid = 1'b1;
      step();
      s1_req_valid = 1'b0; s7_req_valid = 1'b0;
      lat = 0;
      vld = (settle == 1) ? s1_rsp_valid : s7_rsp_valid;
      while (vld !== 1'b1 && lat < 40) begin
        step(); lat++;
        vld = (settle == 1) ? s1_rsp_valid : s7_rsp_valid;
      end
      got = (settle == 1) ? {s1_rsp_cout, s1_rsp_s} : {s7_rsp_cout, s7_rsp_s};
      gop = (settle == 1) ? s1_alu_op : s7_alu_op;
      total++;
      if (lat != settle) begin bad++; $display("FAIL sweep%0d_latency got=%0d want=%0d", settle, lat, settle); end
      total++;
      if (got !== exp || gop !== 2'(i)) begin
        bad++; $display("FAIL sweep%0d_result got=%h op=%b want=%h op=%b", settle, got, gop, exp, 2'(i));
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    end
    total++;
    if ({s1_busy, s7_busy} !== 2'b00) begin bad++; $display("FAIL sweep%0d_idle got=%b%b want=00", settle, s1_busy, s7_busy); end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; chain = 1'b0; flag_clr = 1'b0;
    rsp_ready = 1'b0; m_req_valid = 1'b0; s1_req_valid = 1'b0; s7_req_valid = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flag_clr();
    test_reset_mid_settle();
    test_random();
    test_settle_sweep(1);
    test_settle_sweep(7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
